// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner.
// Optional auto-repeat is enabled by defining BUTTON_AUTO_REPEAT_EN.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } chan_state_e;

   localparam int unsigned BTN_CONFIRM = 32'd0;
   localparam int unsigned BTN_SELECT  = 32'd1;
   localparam int unsigned BTN_EXIT    = 32'd2;
   localparam int unsigned BTN_DATA    = 32'd3;
   localparam int unsigned BTN_POWER   = 32'd4;

   function automatic int unsigned ms_to_cyc(input int unsigned clk_freq, input int unsigned ms);
      return (clk_freq / 32'd1000) * ms;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned event outputs as one bundle.
// master: conditioner side; slave: consumer side that drives the raw buttons.
interface button_conditioner_if #(parameter int unsigned N_BTN = 5);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_long;
   logic [N_BTN-1:0] btn_repeat;

   modport master (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_long, btn_repeat
   );

   modport slave (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_long, btn_repeat
   );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchroniser, consecutive-sample debounce, edge and long-press detect.
// Auto-repeat logic exists only when BUTTON_AUTO_REPEAT_EN is defined.
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DB_CYC   = 32'd4,
   parameter int unsigned LONG_CYC = 32'd10,
   parameter int unsigned REP_CYC  = 32'd3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);

   if ((DB_CYC < 32'd1) || (LONG_CYC < 32'd1) || (REP_CYC < 32'd1)) begin : g_cfg_err
      $error("button_channel: DB_CYC, LONG_CYC and REP_CYC must all be at least 1");
   end

   localparam int unsigned DB_W   = (DB_CYC > 32'd0) ? $clog2(DB_CYC + 32'd1) : 32'd1;
   localparam int unsigned HOLD_W = (LONG_CYC > 32'd0) ? $clog2(LONG_CYC + 32'd1) : 32'd1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

   logic              sync1_q, sync2_q;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              level_q, level_d;
   logic              press_q, release_q, long_q, long_d;
   logic              rise_s, fall_s;
   chan_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   // Debounce: level flips only after DB_CYC consecutive disagreeing samples
   always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = {DB_W{1'b0}};
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end else begin
         db_cnt_d = {DB_W{1'b0}};
      end
      rise_s = level_d & ~level_q;
      fall_s = ~level_d & level_q;
   end

   // Hold FSM, driven by the next level so long fires LONG_CYC edges after the press pulse
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_s) begin
               state_d    = HELD;
               hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (fall_s) begin
               state_d    = IDLE;
               hold_cnt_d = {HOLD_W{1'b0}};
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = LONG;
               hold_cnt_d = HOLD_MAX;
               long_d     = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         LONG: begin
            if (fall_s) begin
               state_d    = IDLE;
               hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
               state_d = LONG;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = {HOLD_W{1'b0}};
         end
      endcase
   end

   // Synchroniser, debounce, FSM state and registered pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_cnt_q   <= {DB_W{1'b0}};
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         state_q    <= IDLE;
         hold_cnt_q <= {HOLD_W{1'b0}};
      end else begin
         sync1_q    <= raw_i;
         sync2_q    <= sync1_q;
         db_cnt_q   <= db_cnt_d;
         level_q    <= level_d;
         press_q    <= rise_s;
         release_q  <= fall_s;
         long_q     <= long_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int unsigned REP_W = (REP_CYC > 32'd0) ? $clog2(REP_CYC + 32'd1) : 32'd1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 32'd1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             repeat_q, repeat_d;

   // rep_cnt runs only while steadily in LONG; it is zero on entry, so the first repeat is REP_CYC after long
   always_comb begin
      rep_cnt_d = {REP_W{1'b0}};
      repeat_d  = 1'b0;
      if ((state_q == LONG) && !fall_s) begin
         if (rep_cnt_q == REP_LAST) begin
            repeat_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
         end
      end else begin
         rep_cnt_d = {REP_W{1'b0}};
      end
   end

   // Repeat counter and pulse register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_cnt_q <= {REP_W{1'b0}};
         repeat_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         repeat_q  <= repeat_d;
      end
   end

   assign repeat_o = repeat_q;
`else
   assign repeat_o = 1'b0;
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and single-cycle event pulses.
// Auto-repeat pulses are generated only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN       = 32'd5,
   parameter int unsigned CLK_FREQ    = 32'd100_000_000,
   parameter int unsigned DEBOUNCE_MS = 32'd20,
   parameter int unsigned LONG_MS     = 32'd1000,
   parameter int unsigned REPEAT_MS   = 32'd200
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.master btn
);

   localparam int unsigned DB_CYC   = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
   localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
   localparam int unsigned REP_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_MS);

   logic [N_BTN-1:0] level_s, press_s, release_s, long_s, repeat_s;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
         .DB_CYC   (DB_CYC),
         .LONG_CYC (LONG_CYC),
         .REP_CYC  (REP_CYC)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .raw_i     (btn.btn_raw[i]),
         .level_o   (level_s[i]),
         .press_o   (press_s[i]),
         .release_o (release_s[i]),
         .long_o    (long_s[i]),
         .repeat_o  (repeat_s[i])
      );
   end

   assign btn.btn_level   = level_s;
   assign btn.btn_press   = press_s;
   assign btn.btn_release = release_s;
   assign btn.btn_long    = long_s;
   assign btn.btn_repeat  = repeat_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with 1 ms = 1 clock cycle.
// Checks a vector table, directed corner sequences, and randomized stimulus against a window-based model.
module tb_button_conditioner;

   localparam int NB  = 5;
   localparam int DB  = 4;
   localparam int LNG = 10;
   localparam int REP = 3;

   logic clk;
   logic reset;

   button_conditioner_if #(.N_BTN(NB)) bif ();

   button_conditioner #(
      .N_BTN       (NB),
      .CLK_FREQ    (1000),
      .DEBOUNCE_MS (DB),
      .LONG_MS     (LNG),
      .REPEAT_MS   (REP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the level flips when the last DB synchronised samples all differ from it.
   bit       m_hist [NB][16384];
   int       m_k;
   logic [NB-1:0] m_level, m_press, m_rel, m_long, m_rep;
   int       m_press_edge [NB];

   // Per-sequence event records (taken from the DUT, compared against constants)
   int seq_cyc;
   int press_n [NB], press_at [NB];
   int rel_n   [NB], rel_at   [NB];
   int long_n  [NB], long_at  [NB];
   int rep_n   [NB];
   int rep_at  [NB][8];
   bit lvl_seen [NB];

   typedef struct {
      logic [NB-1:0] raw;
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] lng;
   } vec_t;

   vec_t tbl [28];

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k     = 0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      m_rep   = '0;
      for (int c = 0; c < NB; c++) m_press_edge[c] = 0;
   endtask

   task automatic model_edge(input logic [NB-1:0] r);
      bit all_diff;
      bit s;
      int e;
      int d;
      m_k++;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      m_rep   = '0;
      for (int c = 0; c < NB; c++) begin
         m_hist[c][m_k] = r[c];
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++) begin
            e = m_k - j;
            s = (e >= 3) ? m_hist[c][e-2] : 1'b0;
            if (s == m_level[c]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) begin
               m_press[c]      = 1'b1;
               m_press_edge[c] = m_k;
            end else begin
               m_rel[c] = 1'b1;
            end
         end else if (m_level[c]) begin
            d = m_k - m_press_edge[c];
            if (d == LNG) m_long[c] = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            if ((d > LNG) && (((d - LNG) % REP) == 0)) m_rep[c] = 1'b1;
`endif
         end
      end
   endtask

   task automatic clear_rec();
      seq_cyc = 0;
      for (int c = 0; c < NB; c++) begin
         press_n[c] = 0; press_at[c] = 0;
         rel_n[c] = 0;   rel_at[c] = 0;
         long_n[c] = 0;  long_at[c] = 0;
         rep_n[c] = 0;
         lvl_seen[c] = 1'b0;
         for (int j = 0; j < 8; j++) rep_at[c][j] = 0;
      end
   endtask

   task automatic step(input logic [NB-1:0] r);
      bif.btn_raw = r;
      @(posedge clk);
      model_edge(r);
      #1;
      chk("m_level",   bif.btn_level,   m_level);
      chk("m_press",   bif.btn_press,   m_press);
      chk("m_release", bif.btn_release, m_rel);
      chk("m_long",    bif.btn_long,    m_long);
      chk("m_repeat",  bif.btn_repeat,  m_rep);
      seq_cyc++;
      for (int c = 0; c < NB; c++) begin
         if (bif.btn_press[c]) begin
            if (press_n[c] == 0) press_at[c] = seq_cyc;
            press_n[c]++;
         end
         if (bif.btn_release[c]) begin
            if (rel_n[c] == 0) rel_at[c] = seq_cyc;
            rel_n[c]++;
         end
         if (bif.btn_long[c]) begin
            if (long_n[c] == 0) long_at[c] = seq_cyc;
            long_n[c]++;
         end
         if (bif.btn_repeat[c]) begin
            if (rep_n[c] < 8) rep_at[c][rep_n[c]] = seq_cyc;
            rep_n[c]++;
         end
         if (bif.btn_level[c]) lvl_seen[c] = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},   bif.btn_level,   '0);
      chk({tag, "_press"},   bif.btn_press,   '0);
      chk({tag, "_release"}, bif.btn_release, '0);
      chk({tag, "_long"},    bif.btn_long,    '0);
      chk({tag, "_repeat"},  bif.btn_repeat,  '0);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases it away from an edge
   task automatic do_reset(input int hold_edges);
      #2 reset = 1'b1;
      #1 chk_all_zero("rst_async");
      for (int i = 0; i < hold_edges; i++) @(posedge clk);
      #1 chk_all_zero("rst_held");
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [NB-1:0] rv;
      int dur [NB];
      int pat [6];

      reset       = 1'b1;
      bif.btn_raw = '0;
      model_reset();
      clear_rec();
      #2 chk_all_zero("por");
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Clean press on channel 0: level at edge 6, long at edge 16, release 6 edges after raw falls
      for (int i = 0; i < 28; i++) begin
         tbl[i].raw   = (i < 20) ? 5'b00001 : 5'b00000;
         tbl[i].level = ((i + 1 >= 6) && (i + 1 <= 25)) ? 5'b00001 : 5'b00000;
         tbl[i].press = (i + 1 == 6)  ? 5'b00001 : 5'b00000;
         tbl[i].rel   = (i + 1 == 26) ? 5'b00001 : 5'b00000;
         tbl[i].lng   = (i + 1 == 16) ? 5'b00001 : 5'b00000;
      end
      clear_rec();
      for (int i = 0; i < 28; i++) begin
         step(tbl[i].raw);
         chk($sformatf("tbl%0d_level", i + 1),   bif.btn_level,   tbl[i].level);
         chk($sformatf("tbl%0d_press", i + 1),   bif.btn_press,   tbl[i].press);
         chk($sformatf("tbl%0d_release", i + 1), bif.btn_release, tbl[i].rel);
         chk($sformatf("tbl%0d_long", i + 1),    bif.btn_long,    tbl[i].lng);
      end
      idle(6);

      // Bounce on channel 1: only the final run of four synchronised 1s is accepted
      pat = '{1, 0, 1, 1, 0, 1};
      clear_rec();
      for (int i = 0; i < 6; i++) step(pat[i] != 0 ? 5'b00010 : 5'b00000);
      for (int i = 0; i < 10; i++) step(5'b00010);
      chk_int("bounce_press_count", press_n[1], 1);
      chk_int("bounce_press_edge", press_at[1], 11);
      idle(12);

      // Short glitch on channel 2
      clear_rec();
      for (int i = 0; i < 3; i++) step(5'b00100);
      idle(12);
      chk_int("glitch_press_count", press_n[2], 0);
      chk_int("glitch_release_count", rel_n[2], 0);
      chk_int("glitch_level_seen", int'(lvl_seen[2]), 0);

      // Release after a long press on channel 0
      clear_rec();
      for (int i = 0; i < 15; i++) step(5'b00001);
      idle(10);
      chk_int("longrel_long_count", long_n[0], 1);
      chk_int("longrel_long_edge", long_at[0], 16);
      chk_int("longrel_release_count", rel_n[0], 1);
      chk_int("longrel_release_edge", rel_at[0] - 15, 6);
      idle(4);

      // Long hold on channel 3 for the auto-repeat behaviour
      clear_rec();
      for (int i = 0; i < 25; i++) step(5'b01000);
      idle(12);
      chk_int("hold25_long_edge", long_at[3], 16);
`ifdef BUTTON_AUTO_REPEAT_EN
      chk_int("hold25_repeat_count", rep_n[3], 4);
      chk_int("hold25_repeat0", rep_at[3][0], 19);
      chk_int("hold25_repeat1", rep_at[3][1], 22);
      chk_int("hold25_repeat2", rep_at[3][2], 25);
`else
      chk_int("hold25_repeat_count", rep_n[3], 0);
`endif

      // Reset mid-hold on channel 0, button still held through reset release
      clear_rec();
      for (int i = 0; i < 12; i++) step(5'b00001);
      chk_int("midhold_level_before_reset", int'(bif.btn_level[0]), 1);
      do_reset(2);
      clear_rec();
      for (int i = 0; i < 20; i++) step(5'b00001);
      chk_int("after_reset_press_edge", press_at[0], 6);
      chk_int("after_reset_long_edge", long_at[0] - press_at[0], 10);
      idle(12);

      // Randomized independent activity on all channels, with one reset in the middle
      rv = '0;
      for (int c = 0; c < NB; c++) dur[c] = $urandom_range(1, 10);
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < NB; c++) begin
            dur[c]--;
            if (dur[c] <= 0) begin
               rv[c]  = ~rv[c];
               dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            end
         end
         step(rv);
         if (i == 750) do_reset(3);
      end
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
